fir_stream_ctrl: RTL
====================

FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample/result width (signed two's complement).
REQ-002 SHALL have parameter TAPS, default 64, FIR tap count; flush length = TAPS-1.
REQ-003 SHALL have parameter LATENCY, default 1, FIR enabled-cycle latency from fir_din to fir_dout, range 1..8.
REQ-004 SHALL have parameter CNT_W, default 20, sample-count width.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  one-cycle run request.
REQ-008 SHALL have port num_samples  in  CNT_W  input sample count, sampled on accepted start.
REQ-009 SHALL have ports busy  out  1  and done  out  1  (busy = run in progress, done = one-cycle completion pulse).
REQ-010 SHALL have ports s_valid  in  1,  s_ready  out  1,  s_data  in  DATA_W  (input sample stream).
REQ-011 SHALL have ports fir_ce  out  1,  fir_clr  out  1,  fir_din  out  DATA_W,  fir_dout  in  DATA_W  (FIR datapath control and data).
REQ-012 SHALL have ports m_valid  out  1,  m_ready  in  1,  m_data  out  DATA_W,  m_last  out  1  (filtered output stream).

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, RUN, FLUSH, DRAIN, WAIT_OUT, DONE.
REQ-014 IDLE: start=1 latches num_samples; if num_samples=0 go to DONE, else go to CLEAR; start in any other state SHALL be ignored.
REQ-015 CLEAR: fir_clr=1 for exactly one cycle, fir_ce=0, then go to RUN.
REQ-016 Advance condition adv = (!m_valid || m_ready); fir_ce SHALL be 1 only when adv holds and the current state supplies a sample.
REQ-017 RUN: s_ready = adv; on s_valid&&s_ready: fir_ce=1, fir_din=s_data, input counter +1; after num_samples accepts go to FLUSH; s_valid=0 SHALL hold fir_ce=0 (no bubble injected).
REQ-018 FLUSH: fir_ce=adv, fir_din=0, s_ready=0; after TAPS-1 enabled cycles go to DRAIN.
REQ-019 DRAIN: fir_ce=adv, fir_din=0; after LATENCY enabled cycles go to WAIT_OUT.
REQ-020 A LATENCY-deep tag shift register SHALL shift on fir_ce; tag=1 for RUN and FLUSH samples, 0 for DRAIN and when clear; it shifts to 0s on fir_clr.
REQ-021 When fir_ce=1 and the tag exiting the shift register =1, the block SHALL load m_data<=fir_dout and set m_valid<=1 on the same edge; untagged exits SHALL be discarded.
REQ-022 m_valid SHALL clear on m_valid&&m_ready unless reloaded on the same edge; m_data SHALL hold stable while m_valid&&!m_ready.
REQ-023 Exactly num_samples+TAPS-1 outputs per run; m_last=1 only with the final one.
REQ-024 WAIT_OUT: fir_ce=0; when m_valid=0 (or final handshake completes) go to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy=1 in all states except IDLE.
REQ-026 fir_din SHALL be 0 whenever fir_ce=0; counters SHALL be CNT_W bits, no wrap within a run (num_samples max 2^CNT_W-1).

Reset
REQ-027 rst=1 at any cycle, including mid-run, SHALL force IDLE and on the next edge: busy=0, done=0, s_ready=0, fir_ce=0, fir_clr=0, fir_din=0, m_valid=0, m_last=0, m_data=0, counters=0, tags=0.
REQ-028 After reset, the first start SHALL pass through CLEAR before any fir_ce.

Verification
REQ-029 TAPS=4, LATENCY=1, num_samples=5, s_valid and m_ready always 1 -> fir_clr pulse, 5+3+1 fir_ce cycles, 8 outputs matching golden convolution, m_last on 8th, done one cycle after.
REQ-030 Same run with m_ready toggling 1/0 each cycle -> identical 8 outputs in order, fir_ce=0 whenever m_valid&&!m_ready, m_data stable while stalled.
REQ-031 s_valid deasserted for 3 cycles after sample 2 -> fir_ce=0 for those 3 cycles, output sequence unchanged versus REQ-029.
REQ-032 num_samples=0 -> busy for 1 cycle, done pulse, no fir_ce, no m_valid.
REQ-033 rst=1 during FLUSH -> all outputs at reset values next cycle; new start with num_samples=2 yields 5 outputs with no residue from aborted run.
REQ-034 start pulsed while busy, and LATENCY=3 run -> extra start ignored; 3 DRAIN cycles; output count still num_samples+TAPS-1.

Source files
------------

// File: rtl/fir_stream_ctrl.sv
// Stream controller for an external FIR datapath: clears it, feeds a counted run of samples,
// flushes TAPS-1 zeros through it and returns exactly num_samples+TAPS-1 filtered results.
module fir_stream_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TAPS    = 64,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              fir_ce,
  output logic              fir_clr,
  output logic [DATA_W-1:0] fir_din,
  input  logic [DATA_W-1:0] fir_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    RUN      = 3'd2,
    FLUSH    = 3'd3,
    DRAIN    = 3'd4,
    WAIT_OUT = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam bit               SINGLE_TAP = (TAPS == 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((TAPS > 1) ? (TAPS - 2) : 0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY - 1);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    num_r, in_cnt_r, ph_cnt_r;
  logic [LATENCY-1:0]  tag_v_r, tag_l_r;
  logic                m_valid_r, m_last_r, busy_r, done_r;
  logic [DATA_W-1:0]   m_data_r;
  logic                adv_s, ce_s, clr_s, s_ready_s, tag_in_v_s, tag_in_l_s, in_last_s;
  logic [DATA_W-1:0]   din_s;

  // Next-state decode and datapath strobes; a sample is only pushed when the output slot can take a result
  always_comb begin
    adv_s      = !m_valid_r || m_ready;
    in_last_s  = (in_cnt_r == (num_r - CNT_W'(1)));
    state_s    = state_r;
    ce_s       = 1'b0;
    clr_s      = 1'b0;
    s_ready_s  = 1'b0;
    din_s      = '0;
    tag_in_v_s = 1'b0;
    tag_in_l_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (num_samples == '0) ? DONE : CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        clr_s   = 1'b1;
        state_s = RUN;
      end
      RUN: begin
        s_ready_s  = adv_s;
        tag_in_v_s = 1'b1;
        tag_in_l_s = SINGLE_TAP && in_last_s;
        if (s_valid && adv_s) begin
          ce_s  = 1'b1;
          din_s = s_data;
          if (in_last_s) begin
            state_s = SINGLE_TAP ? DRAIN : FLUSH;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        ce_s       = adv_s;
        tag_in_v_s = 1'b1;
        tag_in_l_s = (ph_cnt_r == FLUSH_LAST);
        if (adv_s && (ph_cnt_r == FLUSH_LAST)) begin
          state_s = DRAIN;
        end else begin
          state_s = FLUSH;
        end
      end
      DRAIN: begin
        ce_s = adv_s;
        if (adv_s && (ph_cnt_r == DRAIN_LAST)) begin
          state_s = WAIT_OUT;
        end else begin
          state_s = DRAIN;
        end
      end
      WAIT_OUT: begin
        if (adv_s) begin
          state_s = DONE;
        end else begin
          state_s = WAIT_OUT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, run length and progress counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      num_r    <= '0;
      in_cnt_r <= '0;
      ph_cnt_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if ((state_r == IDLE) && start) begin
        num_r <= num_samples;
      end
      if (clr_s) begin
        in_cnt_r <= '0;
      end else if (ce_s && (state_r == RUN)) begin
        in_cnt_r <= in_cnt_r + CNT_W'(1);
      end
      if (state_s != state_r) begin
        ph_cnt_r <= '0;
      end else if (ce_s && ((state_r == FLUSH) || (state_r == DRAIN))) begin
        ph_cnt_r <= ph_cnt_r + CNT_W'(1);
      end
    end
  end

  // Tags travel alongside the FIR pipeline so only real (non-drain) results reach the output
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      tag_v_r <= '0;
      tag_l_r <= '0;
    end else if (ce_s) begin
      tag_v_r <= LATENCY'({tag_v_r, tag_in_v_s});
      tag_l_r <= LATENCY'({tag_l_r, tag_in_l_s});
    end
  end

  // Output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= '0;
    end else if (ce_s && tag_v_r[LATENCY-1]) begin
      m_valid_r <= 1'b1;
      m_last_r  <= tag_l_r[LATENCY-1];
      m_data_r  <= fir_dout;
    end else if (m_valid_r && m_ready) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign s_ready = s_ready_s;
  assign fir_ce  = ce_s;
  assign fir_clr = clr_s;
  assign fir_din = din_s;
  assign m_valid = m_valid_r;
  assign m_last  = m_last_r;
  assign m_data  = m_data_r;

endmodule
